ip_tx_arbiter: RTL and testbench
================================

Name: ip_tx_arbiter

Overview:
- Parametrised N-channel transmit merger for the IP layer. It takes per-protocol frame streams (ICMP, UDP, ARP, future channels) and produces one MAC transmit stream.
- Replaces per-protocol tx outputs with frame-atomic arbitration, a selectable priority mode, an inter-frame gap, and a stall watchdog.
- Sits between the protocol tops and the MAC tx path, single clock domain.

Parameters:
- CH_NUM, 4, number of requesting channels (2..8).
- DATA_W, 8, stream data width.
- PRIO_MODE, 0, 0 = round-robin, 1 = fixed priority with ch0 highest.
- IFG_CYCLES, 12, idle cycles forced after each frame end (>=1).
- TIMEOUT_CYCLES, 2048, watchdog limit in cycles (>=2).

Ports:
- i_clk  in  1  system clock.
- i_rst  in  1  asynchronous, active-high reset.
- i_tx_req  in  CH_NUM  per-channel level request: the channel has a frame ready.
- o_tx_en  out  CH_NUM  one-cycle start pulse to the granted channel.
- i_ch_txsop  in  CH_NUM  per-channel start of frame.
- i_ch_txeop  in  CH_NUM  per-channel end of frame.
- i_ch_txvld  in  CH_NUM  per-channel data valid.
- i_ch_txdata  in  CH_NUM*DATA_W  per-channel data; channel k occupies bits [k*DATA_W +: DATA_W].
- o_mac_txsop  out  1  merged start of frame.
- o_mac_txeop  out  1  merged end of frame.
- o_mac_txvld  out  1  merged data valid.
- o_mac_txdata  out  DATA_W  merged data.
- o_grant_id  out  $clog2(CH_NUM)  index of the current or last granted channel.
- o_busy  out  1  high in every state except IDLE.
- o_timeout  out  1  one-cycle pulse when the watchdog fires.

Behaviour:
- Reset: all outputs 0, FSM in IDLE, round-robin pointer 0, IFG and watchdog counters 0.
- FSM states: IDLE, GRANT, WAIT_SOP, XFER, GAP.
- IDLE:
  - If any i_tx_req bit is set, select a winner, latch it into o_grant_id, go to GRANT.
  - PRIO_MODE=1: winner is the lowest set index.
  - PRIO_MODE=0: winner is the first set index at or after the pointer, wrapping modulo CH_NUM.
- GRANT (1 cycle):
  - o_tx_en[winner]=1, all other bits 0.
  - Round-robin pointer becomes (winner+1) mod CH_NUM.
  - Clear the watchdog and go to WAIT_SOP.
- WAIT_SOP:
  - Wait for i_ch_txsop[winner] & i_ch_txvld[winner], then go to XFER.
  - That beat is forwarded like any XFER beat.
  - A sop from a non-granted channel is ignored.
- XFER:
  - Winner's sop/eop/vld/data are registered onto o_mac_tx*, giving exactly 1 cycle of latency.
  - While vld is low, o_mac_txvld=0 and o_mac_txdata holds its last value.
  - A beat with eop & vld goes to GAP and loads the IFG counter with IFG_CYCLES.
  - A beat with sop and eop together (single-beat frame) is legal and goes straight to GAP.
- Non-granted channels never reach the output. Their requests stay pending and are re-evaluated in the next IDLE.
- GAP:
  - Outputs are 0 and the counter decrements each cycle.
  - At 0 the FSM returns to IDLE, so the minimum spacing from o_mac_txeop to the next o_tx_en is IFG_CYCLES+2 cycles.
- Watchdog:
  - Counts cycles in WAIT_SOP, and cycles in XFER without winner vld; it clears on every forwarded beat.
  - At TIMEOUT_CYCLES it pulses o_timeout.
  - If a frame is open (sop forwarded, no eop yet), it emits one forced beat with o_mac_txeop=1, o_mac_txvld=1 and data 0 so the MAC closes the frame.
  - It then goes to GAP.
- Simultaneous events:
  - eop on the same cycle the watchdog fires: eop wins, no timeout pulse.
  - Requests that arrive during GAP wait for IDLE.
  - A request deasserted after GRANT does not cancel the frame; the watchdog governs.
- Reset mid-frame: outputs drop to 0 immediately (async) with no eop; the MAC side discards the partial frame.
- Widths: all counters are sized by $clog2 of their limit plus 1. There is no arithmetic on data.

Test Plan:
- Single request, CH_NUM=4, req=4'b0010, ch1 sends 60-beat frame 0x00..0x3B -> o_tx_en=4'b0010 one cycle; o_mac_txdata reproduces 0x00..0x3B with 1-cycle latency; sop on first beat, eop on 60th; o_grant_id=1.
- Round-robin, PRIO_MODE=0, req=4'b1111 held, each channel sends 8-beat frames -> grant order 0,1,2,3,0; txeop to next o_tx_en = 14 cycles (IFG_CYCLES=12).
- Fixed priority, PRIO_MODE=1, req=4'b1010 held -> ch1 granted every time and ch3 starved; drop req[1] -> ch3 granted next.
- Interleave rejection: ch0 granted; ch2 toggles sop/vld/data 0xAA during ch0's frame -> output carries only ch0 data and no 0xAA.
- Watchdog, TIMEOUT_CYCLES=16:
  - Granted ch0 never asserts sop -> o_timeout at cycle 16 after GRANT, no MAC beats, returns to IDLE after gap.
  - ch0 stalls vld mid-frame -> forced eop beat with data 0x00, o_timeout pulse.
- Single-beat frame and reset: sop+eop+vld in one beat -> one output beat with sop=eop=vld=1. Assert i_rst during a 40-beat frame -> all outputs 0 immediately, FSM IDLE, next grant starts from ch0.

Source files
------------

// File: rtl/ip_tx_arbiter.sv
// ip_tx_arbiter
// Merges CH_NUM per-protocol transmit streams into one MAC transmit stream.
// A whole frame is owned by one channel from its sop to its eop; other
// channels are blocked until the inter-frame gap has elapsed.
//
// Ports
//   i_clk, i_rst          clock, asynchronous active-high reset
//   i_tx_req[CH_NUM]      level request per channel (frame ready)
//   o_tx_en[CH_NUM]       one-cycle start pulse to the granted channel
//   i_ch_tx{sop,eop,vld}  per-channel stream control
//   i_ch_txdata           per-channel data, channel k at [k*DATA_W +: DATA_W]
//   o_mac_tx*             merged stream, one cycle behind the winner's input
//   o_grant_id            current or last granted channel
//   o_busy                high whenever the FSM is not idle
//   o_timeout             one-cycle pulse when the stall watchdog fires
module ip_tx_arbiter #(
  parameter int CH_NUM         = 4,
  parameter int DATA_W         = 8,
  parameter int PRIO_MODE      = 0,
  parameter int IFG_CYCLES     = 12,
  parameter int TIMEOUT_CYCLES = 2048
) (
  input  logic                       i_clk,
  input  logic                       i_rst,
  input  logic [CH_NUM-1:0]          i_tx_req,
  output logic [CH_NUM-1:0]          o_tx_en,
  input  logic [CH_NUM-1:0]          i_ch_txsop,
  input  logic [CH_NUM-1:0]          i_ch_txeop,
  input  logic [CH_NUM-1:0]          i_ch_txvld,
  input  logic [CH_NUM*DATA_W-1:0]   i_ch_txdata,
  output logic                       o_mac_txsop,
  output logic                       o_mac_txeop,
  output logic                       o_mac_txvld,
  output logic [DATA_W-1:0]          o_mac_txdata,
  output logic [$clog2(CH_NUM)-1:0]  o_grant_id,
  output logic                       o_busy,
  output logic                       o_timeout
);

  localparam int ID_W  = $clog2(CH_NUM);
  localparam int IFG_W = $clog2(IFG_CYCLES) + 1;
  localparam int WD_W  = $clog2(TIMEOUT_CYCLES) + 1;

  // The watchdog fires on the TIMEOUT_CYCLES-th stalled cycle.
  localparam logic [WD_W-1:0]  WD_LIM   = WD_W'(TIMEOUT_CYCLES - 1);
  localparam logic [IFG_W-1:0] IFG_LOAD = IFG_W'(IFG_CYCLES);

  typedef enum logic [2:0] {S_IDLE, S_GRANT, S_WAIT_SOP, S_XFER, S_GAP} state_t;

  state_t            state;
  logic [ID_W-1:0]   rr_ptr;
  logic [IFG_W-1:0]  ifg_cnt;
  logic [WD_W-1:0]   wd_cnt;

  // Per-channel data lanes
  logic [DATA_W-1:0] ch_data [CH_NUM];
  for (genvar k = 0; k < CH_NUM; k++) begin : g_lane
    assign ch_data[k] = i_ch_txdata[k*DATA_W +: DATA_W];
  end

  // Winner's stream, selected by the latched grant
  logic              sel_sop, sel_eop, sel_vld;
  logic [DATA_W-1:0] sel_data;
  assign sel_sop  = i_ch_txsop[o_grant_id];
  assign sel_eop  = i_ch_txeop[o_grant_id];
  assign sel_vld  = i_ch_txvld[o_grant_id];
  assign sel_data = ch_data[o_grant_id];

  // Winner search: scan from index 0 (fixed priority) or from rr_ptr with
  // wrap (round-robin); the first requesting channel found wins.
  logic [ID_W:0]   cand;
  logic [ID_W-1:0] winner;
  logic            found;
  always_comb begin
    cand   = '0;
    winner = '0;
    found  = 1'b0;
    for (int i = 0; i < CH_NUM; i++) begin
      if (PRIO_MODE == 1) begin
        cand = (ID_W+1)'(i);
      end else begin
        cand = {1'b0, rr_ptr} + (ID_W+1)'(i);
        if (cand >= (ID_W+1)'(CH_NUM)) cand = cand - (ID_W+1)'(CH_NUM);
      end
      if (!found && i_tx_req[cand[ID_W-1:0]]) begin
        found  = 1'b1;
        winner = cand[ID_W-1:0];
      end
    end
  end

  assign o_busy = (state != S_IDLE);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state        <= S_IDLE;
      rr_ptr       <= '0;
      ifg_cnt      <= '0;
      wd_cnt       <= '0;
      o_tx_en      <= '0;
      o_grant_id   <= '0;
      o_mac_txsop  <= 1'b0;
      o_mac_txeop  <= 1'b0;
      o_mac_txvld  <= 1'b0;
      o_mac_txdata <= '0;
      o_timeout    <= 1'b0;
    end else begin
      o_tx_en   <= '0;
      o_timeout <= 1'b0;
      case (state)
        S_IDLE: begin
          if (|i_tx_req) begin
            o_grant_id <= winner;
            o_tx_en    <= CH_NUM'(1) << winner;   // high during GRANT
            state      <= S_GRANT;
          end
        end
        S_GRANT: begin
          rr_ptr <= (o_grant_id == ID_W'(CH_NUM - 1)) ? '0 : o_grant_id + ID_W'(1);
          wd_cnt <= '0;
          state  <= S_WAIT_SOP;
        end
        S_WAIT_SOP: begin
          if (sel_sop && sel_vld) begin
            o_mac_txsop  <= 1'b1;
            o_mac_txeop  <= sel_eop;
            o_mac_txvld  <= 1'b1;
            o_mac_txdata <= sel_data;
            wd_cnt       <= '0;
            if (sel_eop) begin
              ifg_cnt <= IFG_LOAD;
              state   <= S_GAP;
            end else begin
              state   <= S_XFER;
            end
          end else begin
            o_mac_txsop <= 1'b0;
            o_mac_txeop <= 1'b0;
            o_mac_txvld <= 1'b0;
            // No frame open yet, so a timeout just abandons the grant.
            if (wd_cnt == WD_LIM) begin
              o_timeout <= 1'b1;
              ifg_cnt   <= IFG_LOAD;
              state     <= S_GAP;
            end else begin
              wd_cnt <= wd_cnt + WD_W'(1);
            end
          end
        end
        S_XFER: begin
          // A valid beat takes precedence, so eop beats the watchdog.
          if (sel_vld) begin
            o_mac_txsop  <= sel_sop;
            o_mac_txeop  <= sel_eop;
            o_mac_txvld  <= 1'b1;
            o_mac_txdata <= sel_data;
            wd_cnt       <= '0;
            if (sel_eop) begin
              ifg_cnt <= IFG_LOAD;
              state   <= S_GAP;
            end
          end else if (wd_cnt == WD_LIM) begin
            // Frame is open: close it with a zero-data eop beat.
            o_timeout    <= 1'b1;
            o_mac_txsop  <= 1'b0;
            o_mac_txeop  <= 1'b1;
            o_mac_txvld  <= 1'b1;
            o_mac_txdata <= '0;
            ifg_cnt      <= IFG_LOAD;
            state        <= S_GAP;
          end else begin
            o_mac_txsop <= 1'b0;
            o_mac_txeop <= 1'b0;
            o_mac_txvld <= 1'b0;
            wd_cnt      <= wd_cnt + WD_W'(1);
          end
        end
        S_GAP: begin
          o_mac_txsop  <= 1'b0;
          o_mac_txeop  <= 1'b0;
          o_mac_txvld  <= 1'b0;
          o_mac_txdata <= '0;
          if (ifg_cnt == '0) state <= S_IDLE;
          else               ifg_cnt <= ifg_cnt - IFG_W'(1);
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ip_tx_arbiter.sv
module tb_ip_tx_arbiter;
  localparam int CH = 4;
  localparam int DW = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // dut0: round-robin, short watchdog
  logic [CH-1:0]    req0, sop0, eop0, vld0, en0;
  logic [CH*DW-1:0] dat0;
  logic             msop0, meop0, mvld0, busy0, to0;
  logic [DW-1:0]    mdat0;
  logic [1:0]       gid0;
  // dut1: fixed priority
  logic [CH-1:0]    req1, sop1, eop1, vld1, en1;
  logic [CH*DW-1:0] dat1;
  logic             msop1, meop1, mvld1, busy1, to1;
  logic [DW-1:0]    mdat1;
  logic [1:0]       gid1;

  ip_tx_arbiter #(.CH_NUM(CH), .DATA_W(DW), .PRIO_MODE(0), .IFG_CYCLES(12), .TIMEOUT_CYCLES(16)) dut0 (
    .i_clk(clk), .i_rst(rst), .i_tx_req(req0), .o_tx_en(en0),
    .i_ch_txsop(sop0), .i_ch_txeop(eop0), .i_ch_txvld(vld0), .i_ch_txdata(dat0),
    .o_mac_txsop(msop0), .o_mac_txeop(meop0), .o_mac_txvld(mvld0), .o_mac_txdata(mdat0),
    .o_grant_id(gid0), .o_busy(busy0), .o_timeout(to0));

  ip_tx_arbiter #(.CH_NUM(CH), .DATA_W(DW), .PRIO_MODE(1), .IFG_CYCLES(12), .TIMEOUT_CYCLES(2048)) dut1 (
    .i_clk(clk), .i_rst(rst), .i_tx_req(req1), .o_tx_en(en1),
    .i_ch_txsop(sop1), .i_ch_txeop(eop1), .i_ch_txvld(vld1), .i_ch_txdata(dat1),
    .o_mac_txsop(msop1), .o_mac_txeop(meop1), .o_mac_txvld(mvld1), .o_mac_txdata(mdat1),
    .o_grant_id(gid1), .o_busy(busy1), .o_timeout(to1));

  typedef struct packed {logic sop; logic eop; logic [7:0] data;} beat_t;

  beat_t exp_q[$];
  int    exp_g0[$];
  int    exp_g1[$];
  int    exp_to[$];
  int    n_tests = 0;
  int    n_fail  = 0;
  int    last_eop_cyc = 0;
  int    saw_aa = 0;
  beat_t mb;
  int    g0x, g1x, tox;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  // dut0 monitor: merged beats, grants, timeout pulses
  always @(negedge clk) begin
    if (!rst) begin
      if (mvld0) begin
        if (mdat0 == 8'hAA) saw_aa++;
        if (meop0) last_eop_cyc = cyc;
        if (exp_q.size() == 0) begin
          n_tests++; n_fail++;
          $display("FAIL beat_extra: got beat sop=%0b eop=%0b data=%0h, expected no beat", msop0, meop0, mdat0);
        end else begin
          mb = exp_q.pop_front();
          chk("beat", {msop0, meop0, mdat0}, mb);
        end
      end
      if (en0 != '0) begin
        if (exp_g0.size() == 0) begin
          n_tests++; n_fail++;
          $display("FAIL grant_extra0: got tx_en %0h, expected none", en0);
        end else begin
          g0x = exp_g0.pop_front();
          chk("grant_en0", en0, 4'b0001 << g0x);
          chk("grant_id0", gid0, g0x);
        end
      end
      if (to0) begin
        if (exp_to.size() == 0) begin
          n_tests++; n_fail++;
          $display("FAIL timeout_extra: got timeout pulse, expected none");
        end else begin
          tox = exp_to.pop_front();
          chk("timeout_pulse", to0, 1);
        end
      end
    end
  end

  // dut1 monitor: grant order only
  always @(negedge clk) begin
    if (!rst && en1 != '0) begin
      if (exp_g1.size() == 0) begin
        n_tests++; n_fail++;
        $display("FAIL grant_extra1: got tx_en %0h, expected none", en1);
      end else begin
        g1x = exp_g1.pop_front();
        chk("grant_en1", en1, 4'b0001 << g1x);
        chk("grant_id1", gid1, g1x);
      end
    end
  end

  task automatic wait_en(input int dut, input int ch, output int c);
    c = -1;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (dut == 0 ? en0[ch] : en1[ch]) begin
        c = cyc;
        break;
      end
    end
    if (c < 0) begin
      n_tests++; n_fail++;
      $display("FAIL wait_en: dut%0d ch%0d got no grant, expected one within 300 cycles", dut, ch);
    end
  endtask

  task automatic wait_idle(input int dut);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 500; i++) begin
      @(negedge clk);
      if (!(dut == 0 ? busy0 : busy1)) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      n_tests++; n_fail++;
      $display("FAIL wait_idle: dut%0d still busy, expected idle within 500 cycles", dut);
    end
  endtask

  task automatic drive0(input int ch, input logic s, input logic e, input logic v, input logic [7:0] d);
    sop0[ch] = s; eop0[ch] = e; vld0[ch] = v;
    dat0[ch*DW +: DW] = d;
  endtask

  task automatic clear0();
    sop0 = '0; eop0 = '0; vld0 = '0; dat0 = '0;
  endtask

  // Drives len back-to-back beats on dut0 channel ch, pushing each expected
  // output beat. noise=1 makes ch2 babble 0xAA beats at the same time.
  task automatic send_frame(input int ch, input int len, input logic [7:0] base,
                            input bit close, input bit noise);
    logic [7:0] d;
    logic       s, e;
    for (int i = 0; i < len; i++) begin
      @(posedge clk); #1;
      d = base + 8'(i);
      s = (i == 0);
      e = close && (i == len - 1);
      drive0(ch, s, e, 1'b1, d);
      if (noise) drive0(2, i[0], 1'b0, 1'b1, 8'hAA);
      exp_q.push_back('{sop: s, eop: e, data: d});
    end
    @(posedge clk); #1;
    clear0();
  endtask

  task automatic beat1(input int ch);
    @(posedge clk); #1;
    sop1[ch] = 1'b1; eop1[ch] = 1'b1; vld1[ch] = 1'b1;
    dat1[ch*DW +: DW] = 8'h5C;
    @(posedge clk); #1;
    sop1 = '0; eop1 = '0; vld1 = '0; dat1 = '0;
  endtask

  task automatic do_reset();
    @(negedge clk); #2 rst = 1'b1;
    @(negedge clk); #2 rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation still running, expected completion");
    $fatal(1, "global timeout");
  end

  initial begin
    int c, t;
    int ord [5];
    ord = '{0, 1, 2, 3, 0};
    req0 = '0; req1 = '0;
    clear0();
    sop1 = '0; eop1 = '0; vld1 = '0; dat1 = '0;

    // Reset state
    repeat (2) @(negedge clk);
    chk("reset_outs", {en0, msop0, meop0, mvld0, mdat0, gid0, busy0, to0}, 0);
    #2 rst = 1'b0;
    @(negedge clk);
    chk("idle_no_req", busy0, 0);

    // Single request on ch1, 60-beat frame 0x00..0x3B
    req0 = 4'b0010;
    exp_g0.push_back(1);
    wait_en(0, 1, c);
    req0 = '0;
    send_frame(1, 60, 8'h00, 1'b1, 1'b0);
    wait_idle(0);
    chk("grant_id_hold", gid0, 1);

    // Round-robin from pointer 0 with all requests held; eop->tx_en = 14
    do_reset();
    req0 = 4'b1111;
    foreach (ord[k]) exp_g0.push_back(ord[k]);
    for (int k = 0; k < 5; k++) begin
      wait_en(0, ord[k], c);
      if (k > 0) chk("rr_gap", c - last_eop_cyc, 14);
      if (k == 4) req0 = '0;
      send_frame(ord[k], 8, 8'(8'h40 + 16 * k), 1'b1, 1'b0);
    end
    wait_idle(0);

    // Interleave rejection: ch2 babbles 0xAA during ch0's frame
    req0 = 4'b0001;
    exp_g0.push_back(0);
    wait_en(0, 0, c);
    req0 = '0;
    send_frame(0, 10, 8'h10, 1'b1, 1'b1);
    wait_idle(0);
    chk("no_aa_forwarded", saw_aa, 0);

    // Watchdog: granted channel never sends sop
    req0 = 4'b0001;
    exp_g0.push_back(0);
    exp_to.push_back(1);
    wait_en(0, 0, c);
    req0 = '0;
    t = -1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (to0) begin
        t = cyc;
        break;
      end
    end
    // 16 stalled cycles, then the registered pulse
    chk("wd_nosop_latency", (t - c >= 16) && (t - c <= 17), 1);
    repeat (12) @(negedge clk);
    chk("wd_gap_busy", busy0, 1);
    @(negedge clk);
    chk("wd_back_idle", busy0, 0);

    // Watchdog: stall mid-frame -> forced eop beat with data 0
    req0 = 4'b0001;
    exp_g0.push_back(0);
    exp_to.push_back(1);
    wait_en(0, 0, c);
    req0 = '0;
    send_frame(0, 5, 8'h30, 1'b0, 1'b0);
    exp_q.push_back('{sop: 1'b0, eop: 1'b1, data: 8'h00});
    wait_idle(0);

    // Single-beat frame
    req0 = 4'b0001;
    exp_g0.push_back(0);
    wait_en(0, 0, c);
    req0 = '0;
    send_frame(0, 1, 8'h5A, 1'b1, 1'b0);
    wait_idle(0);

    // Reset in the middle of a 40-beat frame on ch2
    req0 = 4'b0100;
    exp_g0.push_back(2);
    wait_en(0, 2, c);
    req0 = '0;
    send_frame(2, 20, 8'hC0, 1'b0, 1'b0);
    @(negedge clk); #2 rst = 1'b1;
    #1;
    chk("rst_midframe_outs", {en0, msop0, meop0, mvld0, mdat0, gid0, busy0, to0}, 0);
    chk("rst_midframe_q", exp_q.size(), 0);
    req0 = 4'b1111;
    exp_g0.push_back(0);
    @(negedge clk); #2 rst = 1'b0;
    wait_en(0, 0, c);
    req0 = '0;
    send_frame(0, 1, 8'h11, 1'b1, 1'b0);
    wait_idle(0);

    // Fixed priority: ch1 starves ch3 until req[1] drops
    req1 = 4'b1010;
    exp_g1.push_back(1); exp_g1.push_back(1); exp_g1.push_back(1); exp_g1.push_back(3);
    for (int k = 0; k < 3; k++) begin
      wait_en(1, 1, c);
      if (k == 2) req1 = 4'b1000;
      beat1(1);
    end
    wait_en(1, 3, c);
    req1 = '0;
    beat1(3);
    wait_idle(1);

    repeat (4) @(negedge clk);
    chk("beat_q_empty", exp_q.size(), 0);
    chk("grant0_q_empty", exp_g0.size(), 0);
    chk("grant1_q_empty", exp_g1.size(), 0);
    chk("timeout_q_empty", exp_to.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
